// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment bit order is a,b,c,d,e,f,g from bit 6 down to bit 0.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam int MAX_DIGITS = 8;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1110011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b0001101;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/disp_freq_scan_if.sv
// Value/strobe inputs and display pin outputs of the scan driver.
// master drives value/load/blank; slave is the driver itself.
interface disp_freq_scan_if
    import disp_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank;
    seg_t                seg_out;
    logic [DIGITS-1:0]   an_out;
    logic                frame_tick;

    modport master (
        output value, load, blank,
        input  seg_out, an_out, frame_tick
    );

    modport slave (
        input  value, load, blank,
        output seg_out, an_out, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
// Output is active-high, bit6..bit0 = a..g.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/disp_freq_scan.sv
// Multiplexed 7-segment driver with frame-synchronous value commit
// and optional leading-zero blanking.
module disp_freq_scan
    import disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
)(
    input  logic           clk,
    input  logic           rst,
    disp_freq_scan_if.slave bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic [VW-1:0]     disp_q, disp_d;
    logic              pend_q, pend_d;
    logic              fb_q, fb_d;
    logic              tick_q, tick_d;
    seg_t              seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              tc;
    logic              fb;
    logic [3:0]        cur_hex;
    logic              cur_dark;
    logic              zero_run;
    logic [DIGITS-1:0] onehot;
    seg_t              cur_seg;

    seg7_decode u_dec (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            fb_q     <= 1'b0;
            tick_q   <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= '0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            fb_q     <= fb_d;
            tick_q   <= tick_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    always_comb begin
        tc    = (pre_q == PRE_LAST);
        fb    = tc && (idx_q == IDX_LAST);
        pre_d = tc ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        shadow_d = bus.load ? bus.value : shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        // A load on the boundary itself bypasses the shadow stage.
        if (bus.load && fb) begin
            disp_d = bus.value;
            pend_d = 1'b0;
        end else if (fb) begin
            if (pend_q) begin
                disp_d = shadow_q;
            end
            pend_d = 1'b0;
        end else if (bus.load) begin
            pend_d = 1'b1;
        end

        // Extra stage aligns the tick with an_out returning to digit 0.
        fb_d   = fb;
        tick_d = fb_q;
    end

    always_comb begin
        cur_hex  = '0;
        cur_dark = 1'b0;
        zero_run = 1'b1;
        onehot   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_hex   = disp_q[4*i +: 4];
                cur_dark  = BLANK_LZ && zero_run && (i != 0);
                onehot[i] = 1'b1;
            end
        end

        an_d  = bus.blank ? '0 : onehot;
        seg_d = (bus.blank || cur_dark) ? SEG_BLANK : cur_seg;
    end

    assign bus.seg_out    = seg_q;
    assign bus.an_out     = an_q;
    assign bus.frame_tick = tick_q;

endmodule
